// File: rtl/multiword_add_sequencer_pkg.sv
// Shared FSM encodings and default geometry for the multi-word add sequencer.
package multiword_add_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_N     = 8;
    localparam int DEF_WORDS = 4;

endpackage

// File: rtl/ripple_carry_adder.sv
// N-bit ripple-carry adder; the single shared datapath of the sequencer.
module ripple_carry_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[N];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Adds WORDS x N-bit operands one word per cycle through one shared adder.
// Define MWADD_SUB_EN to add a 'sub' port selecting a - b.
module multiword_add_sequencer
    import multiword_add_sequencer_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WORDS = DEF_WORDS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic               cin,
`ifdef MWADD_SUB_EN
    input  logic               sub,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] sum,
    output logic               cout,
    output logic               busy
);

    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          out_valid_q, out_valid_d;

    logic [N-1:0]  add_a, add_b, add_s;
    logic          add_co;

    assign add_a = a_q[idx_q*N +: N];

`ifdef MWADD_SUB_EN
    logic sub_q, sub_d;
    // Subtraction is a + ~b + 1: invert each B word, seed carry with 1.
    assign add_b = b_q[idx_q*N +: N] ^ {N{sub_q}};
`else
    assign add_b = b_q[idx_q*N +: N];
`endif

    ripple_carry_adder #(.N(N)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_s),
        .cout (add_co)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
`ifdef MWADD_SUB_EN
        sub_d       = sub_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
`ifdef MWADD_SUB_EN
                    sub_d   = sub;
                    carry_d = sub ? 1'b1 : cin;
`else
                    carry_d = cin;
`endif
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[idx_q*N +: N] = add_s;
                carry_d = add_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    idx_d       = '0;
                    cout_d      = add_co;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef MWADD_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
`ifdef MWADD_SUB_EN
            sub_q       <= sub_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer (N=8, WORDS=4).
module tb_multiword_add_sequencer;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b, sum;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic         cout;
    logic         busy;
`ifdef MWADD_SUB_EN
    logic         sub;
`endif

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    logic [W-1:0] hold_sum;
    logic         hold_cout;

    always #5 clk = ~clk;

    multiword_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef MWADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pops one expected result per output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("sum", 64'(sum), 64'(mon_e.s));
                chk("cout", 64'(cout), 64'(mon_e.c));
            end
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic ts);
        int   n;
        logic [W:0] full;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", 64'(in_ready), 64'd1);
        a = ta;
        b = tb;
        cin = tc;
`ifdef MWADD_SUB_EN
        sub = ts;
`endif
        in_valid = 1'b1;
        if (ts) full = {1'b0, ta} + {1'b0, ~tb} + 1'b1;
        else    full = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        sb.push_back('{s: full[W-1:0], c: full[W]});
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        cin = 1'b1;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (!out_valid && l < 20) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
`ifdef MWADD_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);

        out_ready = 1'b1;
        send(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
        chk("run_busy", 64'(busy), 64'd1);
        chk("run_in_ready", 64'(in_ready), 64'd0);
        wait_done(lat);
        chk("latency1", 64'(lat), 64'd4);
        @(posedge clk); #1;
        chk("ov_one_cycle", 64'(out_valid), 64'd0);
        chk("ready_after_drain", 64'(in_ready), 64'd1);

        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        wait_done(lat);
        chk("latency2", 64'(lat), 64'd4);
        @(posedge clk); #1;

        send(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0);
        wait_done(lat);
        chk("latency3", 64'(lat), 64'd4);
        @(posedge clk); #1;

        out_ready = 1'b0;
        send(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
        wait_done(lat);
        chk("latency_bp", 64'(lat), 64'd4);
        hold_sum = sum;
        hold_cout = cout;
        chk("bp_sum_val", 64'(sum), 64'h100);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                a = 32'h0F0F0F0F;
                b = 32'h01010101;
                in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_sum_stable", 64'(sum), 64'(hold_sum));
            chk("bp_cout_stable", 64'(cout), 64'(hold_cout));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_drained", 64'(out_valid), 64'd0);
        chk("bp_idle", 64'(in_ready), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("bp_no_queued", 64'(out_valid), 64'd0);
        chk("bp_still_idle", 64'(busy), 64'd0);

        send(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb.pop_back());
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_sum", 64'(sum), 64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        send(32'd1, 32'd2, 1'b0, 1'b0);
        wait_done(lat);
        chk("latency_post_rst", 64'(lat), 64'd4);
        @(posedge clk); #1;

`ifdef MWADD_SUB_EN
        send(32'd5, 32'd7, 1'b1, 1'b1);
        wait_done(lat);
        chk("sub_lat1", 64'(lat), 64'd4);
        @(posedge clk); #1;
        send(32'd7, 32'd5, 1'b0, 1'b1);
        wait_done(lat);
        chk("sub_lat2", 64'(lat), 64'd4);
        @(posedge clk); #1;
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiword_add_sequencer.md
Name: multiword_add_sequencer

Overview:
- Multi-cycle controller that adds wide operands (WORDS x N bits) by reusing one N-bit ripple_carry_adder instance.
- Processes one word per cycle, LSW first, and registers the carry between words.
- Valid/ready handshake on both input and output sides.
- Sits between a wide-operand producer (e.g. accumulator or bignum unit) and a single area-cheap adder datapath.

Parameters:
- N, 8, word width of the shared adder in bits
- WORDS, 4, number of N-bit words per operand (>=1); total width W = N*WORDS

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block idle and can accept a request
- a  input  W  operand A
- b  input  W  operand B
- cin  input  1  carry into the LSW
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  W  registered result
- cout  output  1  carry out of the MSW
- busy  output  1  high in RUN or DONE

Behaviour:
- One clock; reset is synchronous, active-high.
- Reset values: in_ready=1 (asserted in the first cycle after reset), out_valid=0, busy=0, sum=0, cout=0, word index=0, carry register=0, state=IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b into operand registers; carry_reg<=cin; idx<=0; go to RUN.
- RUN (in_ready=0):
  - Adder inputs: a_reg[idx*N +: N], b_reg[idx*N +: N], carry_reg.
  - Each edge: sum[idx*N +: N]<=adder sum; carry_reg<=adder cout; idx<=idx+1.
  - At idx==WORDS-1: go to DONE, cout<=adder cout, out_valid<=1.
- DONE:
  - Hold sum, cout, out_valid stable until out_ready is sampled high.
  - On out_valid&&out_ready: out_valid<=0; go to IDLE.
- Latency: out_valid rises exactly WORDS clock edges after the accepting edge.
- Throughput: one result per WORDS+2 cycles with out_ready held high.
- No same-cycle accept on result drain: in_ready is low in DONE; the next accept occurs at the earliest one cycle after the drain.
- Input changes after acceptance are ignored (operands are registered).
- in_valid while busy is ignored and is not queued.
- WORDS=1: single RUN cycle, then DONE.
- idx width: max(1, $clog2(WORDS)).
- Arithmetic is unsigned modulo 2^W; cout is the true carry out of the MSW.
- Reset asserted mid-RUN or in DONE: abort immediately; all outputs and registers return to reset values on that edge; the partial result is discarded.
- sum bits of words not yet written during RUN keep their previous values; sum is only meaningful when out_valid=1.

Optional Feature:
- Macro: MWADD_SUB_EN.
- Defined:
  - Adds port sub (input, 1), latched on accept.
  - When sub=1: the B word is inverted before the adder, and carry_reg is initialised to 1 (cin ignored). Result is a-b mod 2^W.
  - cout=1 means no borrow (a>=b).
- Undefined: no sub port; addition only; no inverter logic.

Decomposition:
- Shared header (include file) holds:
  - FSM state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default N and WORDS constants.
- One natural sub-module: the existing ripple_carry_adder #(N), instantiated once as the shared datapath.
- All control (FSM, idx counter, carry register, operand/result registers) lives in multiword_add_sequencer.

Test Plan (N=8, WORDS=4):
- Basic carry ripple: a=32'h000000FF, b=32'h00000001, cin=0, out_ready=1 -> sum=32'h00000100, cout=0; out_valid high exactly 4 edges after accept, for 1 cycle; in_ready back to 1 the cycle after drain.
- Full-width overflow: a=32'hFFFFFFFF, b=32'h00000001, cin=0 -> sum=32'h00000000, cout=1.
- Carry-in through all words: a=32'hAAAAAAAA, b=32'h55555555, cin=1 -> sum=32'h00000000, cout=1.
- Backpressure: same as the first case with out_ready=0 for 5 cycles after out_valid -> sum, cout and out_valid stable; in_ready=0; a second in_valid pulse is ignored. Raise out_ready -> one handshake, then IDLE.
- Reset mid-operation: accept a=32'h12345678, b=32'h11111111; assert rst after 2 RUN cycles -> next cycle out_valid=0, busy=0, sum=0, cout=0, in_ready=1. A new request then completes normally (a=1, b=2 -> sum=3).
- MWADD_SUB_EN build: a=5, b=7, sub=1 -> sum=32'hFFFFFFFE, cout=0. Then a=7, b=5, sub=1 -> sum=2, cout=1.
